// File: rtl/seg_disp_ctrl_pkg.sv
// Shared constants for the seven-segment display sequencer:
// decoder glyph codes, request modes and FSM states.
package seg_disp_ctrl_pkg;

    localparam logic [3:0] SEG_OFF  = 4'hA;
    localparam logic [3:0] SEG_DASH = 4'hB;
    localparam logic [3:0] SEG_H    = 4'hC;
    localparam logic [3:0] SEG_L    = 4'hD;
    localparam logic [3:0] SEG_E    = 4'hE;
    localparam logic [3:0] SEG_P    = 4'hF;

    typedef enum logic [1:0] {
        MODE_NUM   = 2'd0,
        MODE_HELP  = 2'd1,
        MODE_DASH  = 2'd2,
        MODE_BLANK = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Digit 0 stays lit so a zero value still shows one "0".
    function automatic logic [3:0] lz_en(
        input logic [15:0] bcd,
        input logic        blank
    );
        logic [3:0] en;
        en = 4'hF;
        if (blank) begin
            en[3] = (bcd[15:12] != 4'h0);
            en[2] = en[3] | (bcd[11:8] != 4'h0);
            en[1] = en[2] | (bcd[7:4] != 4'h0);
        end
        return en;
    endfunction

endpackage

// File: rtl/seg_disp_ctrl_dd_adjust.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more
// so the following left shift carries correctly into the next digit.
module seg_disp_ctrl_dd_adjust (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/seg_disp_ctrl.sv
// Four-digit display sequencer: binary-to-BCD conversion, blanking and
// message substitution, committing a complete image in a single edge.
module seg_disp_ctrl
    import seg_disp_ctrl_pkg::*;
#(
    parameter int WIDTH   = 14,
    parameter int MAX_VAL = 9999,
    parameter int NDIG    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WIDTH-1:0]  value,
    input  logic [1:0]        mode,
    input  logic              blank_lz,
    output logic [4*NDIG-1:0] digit,
    output logic [NDIG-1:0]   dig_en,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int SRW = 16 + WIDTH;
    localparam int CW  = $clog2(WIDTH);

    state_e           r_state;
    state_e           w_next;
    mode_e            r_mode;
    logic             r_blank;
    logic             r_over;
    logic [SRW-1:0]   r_sr;
    logic [CW-1:0]    r_cnt;
    logic             w_in_range;
    logic             w_num_ok;
    logic [15:0]      w_adj;
    logic [SRW-1:0]   w_sr_next;
    logic [15:0]      w_bcd;

    assign w_in_range = (value <= WIDTH'(MAX_VAL));
    assign w_num_ok   = (mode == MODE_NUM) && w_in_range;
    assign w_bcd      = r_sr[SRW-1 -: 16];
    assign busy       = (r_state != ST_IDLE);

    for (genvar g = 0; g < 4; g++) begin : g_adj
        seg_disp_ctrl_dd_adjust u_adj (
            .i_nib (r_sr[WIDTH+4*g +: 4]),
            .o_nib (w_adj[4*g +: 4])
        );
    end

    assign w_sr_next = {w_adj[14:0], r_sr[WIDTH-1:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_next = w_num_ok ? ST_SHIFT : ST_COMMIT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == '0) begin
                    w_next = ST_COMMIT;
                end
            end
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_NUM;
            r_blank <= 1'b0;
            r_over  <= 1'b0;
            r_sr    <= '0;
            r_cnt   <= '0;
            digit   <= {4{SEG_OFF}};
            dig_en  <= '0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_mode  <= mode_e'(mode);
                        r_blank <= blank_lz;
                        r_over  <= (mode == MODE_NUM) && !w_in_range;
                        r_sr    <= {16'h0, value};
                        r_cnt   <= CW'(WIDTH - 1);
                    end
                end
                ST_SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt - CW'(1);
                end
                ST_COMMIT: begin
                    done <= 1'b1;
                    ovf  <= 1'b0;
                    unique case (r_mode)
                        MODE_NUM: begin
                            if (r_over) begin
                                digit  <= {4{SEG_DASH}};
                                dig_en <= 4'hF;
                                ovf    <= 1'b1;
                            end else begin
                                digit  <= w_bcd;
                                dig_en <= lz_en(w_bcd, r_blank);
                            end
                        end
                        MODE_HELP: begin
                            digit  <= {SEG_H, SEG_E, SEG_L, SEG_P};
                            dig_en <= 4'hF;
                        end
                        MODE_DASH: begin
                            digit  <= {4{SEG_DASH}};
                            dig_en <= 4'hF;
                        end
                        MODE_BLANK: begin
                            digit  <= {4{SEG_OFF}};
                            dig_en <= 4'h0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seg_disp_ctrl.md
Name: seg_disp_ctrl

Overview:
- Sequencing controller for the four-digit seven-segment display.
- Accepts a binary value or a message request and converts binary to BCD with an iterative shift-add-3 (double-dabble) FSM.
- Applies leading-zero blanking and overflow/message substitution, then drives the per-digit code and enable inputs of four seven_seg decoder instances at top level.
- The display holds the last committed image until a new conversion completes, so it never shows partial results.

Parameters:
- WIDTH, 14, width of the binary input value.
- MAX_VAL, 9999, largest value shown numerically; anything above it is overflow.
- NDIG, 4, number of digits. Fixed at 4; the parameter exists only for documentation and assertions.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  request strobe; sampled only in IDLE.
- value  in  WIDTH  binary value; sampled with load.
- mode  in  2  0=number, 1="HELP", 2="----", 3=blank; sampled with load.
- blank_lz  in  1  1=suppress leading zeros; sampled with load.
- digit  out  16  four 4-bit decoder codes; [3:0]=rightmost digit, [15:12]=leftmost.
- dig_en  out  4  per-digit enable to the decoder en input; bit i belongs to digit i.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle pulse in the cycle the new image becomes visible.
- ovf  out  1  sticky until next commit; 1 = last numeric request exceeded MAX_VAL.

Behaviour:
- Reset (async, rst_n=0), effective immediately, including mid-conversion:
  - state=IDLE; digit=16'hAAAA (all off code); dig_en=4'b0000.
  - busy=0, done=0, ovf=0; shift register and counter cleared.
  - A partial conversion is discarded.
- States: IDLE, SHIFT, COMMIT.
- IDLE:
  - busy=0.
  - On load=1: latch value, mode and blank_lz; set busy=1.
  - mode=0 with value<=MAX_VAL: go to SHIFT, counter=WIDTH-1, shift register = {16'h0, value}.
  - Any other case: go straight to COMMIT.
- SHIFT:
  - Each cycle, each BCD nibble >=5 gets +3, then the whole register shifts left by 1.
  - The counter decrements; after exactly WIDTH shift cycles, go to COMMIT.
- COMMIT (one cycle), outputs registered at the exit edge:
  - mode=0, in range: digit = BCD result. With blank_lz=1, dig_en[i]=0 for each leading zero digit i=3..1; digit 0 is always enabled, so value 0 shows a single "0". With blank_lz=0, dig_en=4'hF. ovf cleared.
  - mode=0, value>MAX_VAL: digit=16'hBBBB (dash code), dig_en=4'hF, ovf=1.
  - mode=1: digit={C,E,D,F} (H,E,L,P left to right), dig_en=4'hF, ovf=0.
  - mode=2: digit=16'hBBBB, dig_en=4'hF, ovf=0.
  - mode=3: digit=16'hAAAA, dig_en=4'h0, ovf=0.
  - done=1 for exactly the cycle after the COMMIT exit edge; busy falls at the same edge; state returns to IDLE.
- Latency, measured from the edge sampling load (edge k):
  - Numeric request: image and done visible after edge k+WIDTH+1 (k+15 by default).
  - Message or overflow request: image and done visible after edge k+1.
  - busy is high from after edge k up to and including edge k+latency.
- load while busy=1 is ignored entirely: no queuing, no effect on latched inputs. It must be re-asserted after done.
- load in the same cycle as done is accepted, because the state is IDLE then.
- value/mode changes while busy have no effect.
- digit and dig_en change only at a COMMIT exit edge or at reset.

Decomposition:
- constants.vh gains the decoder code defines SEG_OFF=4'hA, SEG_DASH=4'hB, SEG_H=4'hC, SEG_L=4'hD, SEG_E=4'hE, SEG_P=4'hF.
- constants.vh also gains the mode encodings MODE_NUM/MODE_HELP/MODE_DASH/MODE_BLANK and the state encodings.
- One combinational sub-module, dd_adjust: 4-bit in, 4-bit out, adds 3 when the input is >=5. It is instantiated 4 times in the SHIFT datapath.
- seven_seg is not instantiated inside this block; the top level wires digit[4i+3:4i] and dig_en[i] to four seven_seg instances.

Test Plan:
- Reset then idle: rst_n low → digit=16'hAAAA, dig_en=0, busy=0, done=0. Release reset with no load → outputs unchanged for 20 cycles.
- Numeric, blank_lz=0: load value=1234 → busy for 15 cycles, done pulse at k+15, digit=16'h1234, dig_en=4'hF, ovf=0. Then value=9999 → 16'h9999.
- Leading-zero blanking, blank_lz=1: value=42 → digit=16'h0042, dig_en=4'b0011. value=0 → dig_en=4'b0001. value=1000 → dig_en=4'hF.
- Overflow and messages: value=10000, mode=0 → done after 1 cycle, digit=16'hBBBB, ovf=1. Then mode=1 → digit=16'hCEDF, ovf=0. Then mode=3 → dig_en=0.
- Busy collision: load 1234, then load 5678 at cycle k+5 → second request ignored, final digit=16'h1234. A load on the done cycle with 5678 → 16'h5678 after 15 further cycles.
- Mid-conversion reset: pulse rst_n low at cycle k+7 of a 9876 conversion → immediate 16'hAAAA/dig_en=0/busy=0, no done pulse. A fresh load of 321 then completes normally.
